// File: rtl/mips_pkg.sv
// Shared opcode/funct/ALU encodings, FSM state codes and the control word
// used by the multicycle MIPS controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       bne_sel;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       illegal;
  } ctrl_t;

  // Successor of DECODE; FETCH doubles as the "unsupported opcode" result.
  function automatic state_t decode_target(input logic [5:0] op, input bit en_bne);
    state_t t;
    t = S_FETCH;
    case (op)
      OP_LW, OP_SW: t = S_MEMADR;
      OP_RTYPE:     t = S_EXEC;
      OP_BEQ:       t = S_BRANCH;
      OP_BNE:       t = en_bne ? S_BRANCH : S_FETCH;
      OP_ADDI:      t = S_ADDIEX;
      OP_J:         t = S_JUMP;
      default:      t = S_FETCH;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational R-type funct decoder: ALU operation plus an unsupported-funct flag.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multiciclo_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared memory/ALU datapath with
// Moore control words decoded from the state register.
module mips_multiciclo_ctrl
  import mips_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter bit EN_BNE  = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pc_en,
  output logic               i_or_d,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_control,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_out
);

  state_t     state;
  logic [5:0] op_q;
  logic       funct_bad_q;
  logic [2:0] dec_alu;
  logic       dec_bad;
  state_t     decode_next;
  ctrl_t      c;

  mips_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_control (dec_alu),
    .illegal     (dec_bad)
  );

  assign decode_next = decode_target(opcode, EN_BNE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_FETCH;
      op_q        <= '0;
      funct_bad_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          state <= decode_next;
          op_q  <= opcode;
        end
        S_MEMADR: state <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state <= S_MEMWB;
        S_EXEC: begin
          state       <= S_ALUWB;
          funct_bad_q <= dec_bad;
        end
        S_ADDIEX: state <= S_ADDIWB;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.ir_write    = 1'b1;
        c.alu_src_b   = 2'b01;
        c.alu_control = ALU_ADD;
        c.pc_write    = 1'b1;
      end
      // Speculative branch target is computed here and parked in ALUOut.
      S_DECODE: begin
        c.alu_src_b   = 2'b11;
        c.alu_control = ALU_ADD;
        c.illegal     = (decode_next == S_FETCH);
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = 2'b10;
        c.alu_control = ALU_ADD;
      end
      S_MEMRD: c.i_or_d = 1'b1;
      S_MEMWR: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = dec_alu;
        c.illegal     = dec_bad;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = ~funct_bad_q;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = ALU_SUB;
        c.pc_src      = 2'b01;
        c.branch      = 1'b1;
        c.bne_sel     = EN_BNE && (op_q == OP_BNE);
      end
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
  end

  // Enables are masked combinationally so nothing commits while reset is high.
  assign pc_en       = ~reset & (c.pc_write | (c.branch & (zero ^ c.bne_sel)));
  assign ir_write    = ~reset & c.ir_write;
  assign mem_write   = ~reset & c.mem_write;
  assign reg_write   = ~reset & c.reg_write;
  assign illegal_op  = ~reset & c.illegal;
  assign i_or_d      = c.i_or_d;
  assign mem_to_reg  = c.mem_to_reg;
  assign reg_dst     = c.reg_dst;
  assign alu_src_a   = c.alu_src_a;
  assign alu_src_b   = c.alu_src_b;
  assign pc_src      = c.pc_src;
  assign alu_control = c.alu_control;
  assign state_out   = STATE_W'(state);

endmodule

// File: tb/tb_mips_multiciclo_ctrl.sv
// Directed bench for mips_multiciclo_ctrl: driver queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_mips_multiciclo_ctrl;
  import mips_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pc_en, i_or_d, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
  logic       alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state_out;

  mips_multiciclo_ctrl #(.STATE_W(4), .EN_BNE(1'b1)) dut (
    .clock       (clock),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .pc_en       (pc_en),
    .i_or_d      (i_or_d),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .mem_to_reg  (mem_to_reg),
    .reg_dst     (reg_dst),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .alu_control (alu_control),
    .illegal_op  (illegal_op),
    .state_out   (state_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] st;
    logic       pe, iod, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    logic       il;
  } obs_t;

  typedef struct {
    string nm;
    obs_t  e;
  } item_t;

  item_t sb_q[$];
  int    errors = 0;
  int    checks = 0;
  item_t cur;
  obs_t  act;

  function automatic obs_t mk(input logic [3:0] st, input logic pe, iod, mw, irw, m2r, rd, rw, sa,
                              input logic [1:0] sbv, psv, input logic [2:0] ac, input logic il);
    obs_t o;
    o.st = st; o.pe = pe; o.iod = iod; o.mw = mw; o.irw = irw; o.m2r = m2r;
    o.rd = rd; o.rw = rw; o.sa = sa; o.sb = sbv; o.ps = psv; o.ac = ac; o.il = il;
    return o;
  endfunction

  // Hand-written expected control words per state.
  obs_t RST, F, MA, MR, MWB, MWR, AIX, AIWB, JMP, MWB_RST;
  function automatic obs_t D(input logic il);
    return mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, il);
  endfunction
  function automatic obs_t EX(input logic [2:0] ac, input logic il);
    return mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, ac, il);
  endfunction
  function automatic obs_t AWB(input logic rw);
    return mk(4'd7, 0, 0, 0, 0, 0, 1, rw, 0, 2'b00, 2'b00, 3'b000, 1'b0);
  endfunction
  function automatic obs_t BR(input logic pe);
    return mk(4'd8, pe, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 1'b0);
  endfunction

  task automatic cyc(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input string nm, input obs_t e);
    item_t it;
    @(posedge clock);
    #1;
    reset  = rst;
    opcode = op;
    funct  = fn;
    zero   = z;
    it.nm  = nm;
    it.e   = e;
    sb_q.push_back(it);
  endtask

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      act = {state_out, pc_en, i_or_d, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
             alu_src_a, alu_src_b, pc_src, alu_control, illegal_op};
      checks++;
      if (act !== cur.e) begin
        errors++;
        $display("FAIL %s: got %h required %h", cur.nm, act, cur.e);
      end
    end
  end

  initial begin
    RST     = mk(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
    F       = mk(4'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
    MA      = mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
    MR      = mk(4'd3, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    MWB     = mk(4'd4, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    MWB_RST = mk(4'd4, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    MWR     = mk(4'd5, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    AIX     = mk(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
    AIWB    = mk(4'd10, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    JMP     = mk(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0);

    cyc(1, 6'd0, 6'd0, 0, "reset0", RST);
    cyc(1, 6'd0, 6'd0, 1, "reset1", RST);
    // lw: 5 clocks
    cyc(0, OP_LW, 6'd0, 1, "lw_fetch", F);
    cyc(0, OP_LW, 6'd0, 0, "lw_decode", D(0));
    cyc(0, OP_LW, 6'd0, 0, "lw_memadr", MA);
    cyc(0, OP_LW, 6'd0, 0, "lw_memrd", MR);
    cyc(0, OP_LW, 6'd0, 0, "lw_memwb", MWB);
    // sw: 4 clocks
    cyc(0, OP_SW, 6'd0, 0, "sw_fetch", F);
    cyc(0, OP_SW, 6'd0, 0, "sw_decode", D(0));
    cyc(0, OP_SW, 6'd0, 0, "sw_memadr", MA);
    cyc(0, OP_SW, 6'd0, 0, "sw_memwr", MWR);
    // R-type sub, bad funct, and (flag must clear again)
    cyc(0, OP_RTYPE, FN_SUB, 0, "sub_fetch", F);
    cyc(0, OP_RTYPE, FN_SUB, 0, "sub_decode", D(0));
    cyc(0, OP_RTYPE, FN_SUB, 0, "sub_exec", EX(3'b110, 0));
    cyc(0, OP_RTYPE, FN_SUB, 0, "sub_aluwb", AWB(1));
    cyc(0, OP_RTYPE, 6'b111111, 0, "badfn_fetch", F);
    cyc(0, OP_RTYPE, 6'b111111, 0, "badfn_decode", D(0));
    cyc(0, OP_RTYPE, 6'b111111, 0, "badfn_exec", EX(3'b010, 1));
    cyc(0, OP_RTYPE, 6'b111111, 0, "badfn_aluwb", AWB(0));
    cyc(0, OP_RTYPE, FN_AND, 0, "and_fetch", F);
    cyc(0, OP_RTYPE, FN_AND, 0, "and_decode", D(0));
    cyc(0, OP_RTYPE, FN_AND, 0, "and_exec", EX(3'b000, 0));
    cyc(0, OP_RTYPE, FN_AND, 0, "and_aluwb", AWB(1));
    cyc(0, OP_RTYPE, FN_SLT, 0, "slt_fetch", F);
    cyc(0, OP_RTYPE, FN_SLT, 0, "slt_decode", D(0));
    cyc(0, OP_RTYPE, FN_SLT, 0, "slt_exec", EX(3'b111, 0));
    cyc(0, OP_RTYPE, FN_SLT, 0, "slt_aluwb", AWB(1));
    // addi
    cyc(0, OP_ADDI, 6'd0, 0, "addi_fetch", F);
    cyc(0, OP_ADDI, 6'd0, 0, "addi_decode", D(0));
    cyc(0, OP_ADDI, 6'd0, 0, "addi_ex", AIX);
    cyc(0, OP_ADDI, 6'd0, 0, "addi_wb", AIWB);
    // branches: zero driven during BRANCH
    cyc(0, OP_BEQ, 6'd0, 0, "beqt_fetch", F);
    cyc(0, OP_BEQ, 6'd0, 0, "beqt_decode", D(0));
    cyc(0, OP_BEQ, 6'd0, 1, "beq_taken", BR(1));
    cyc(0, OP_BEQ, 6'd0, 0, "beqn_fetch", F);
    cyc(0, OP_BEQ, 6'd0, 0, "beqn_decode", D(0));
    cyc(0, OP_BEQ, 6'd0, 0, "beq_not_taken", BR(0));
    cyc(0, OP_BNE, 6'd0, 0, "bnet_fetch", F);
    cyc(0, OP_BNE, 6'd0, 0, "bnet_decode", D(0));
    cyc(0, OP_BNE, 6'd0, 0, "bne_taken", BR(1));
    cyc(0, OP_BNE, 6'd0, 0, "bnen_fetch", F);
    cyc(0, OP_BNE, 6'd0, 0, "bnen_decode", D(0));
    cyc(0, OP_BNE, 6'd0, 1, "bne_not_taken", BR(0));
    // jump
    cyc(0, OP_J, 6'd0, 0, "j_fetch", F);
    cyc(0, OP_J, 6'd0, 0, "j_decode", D(0));
    cyc(0, OP_J, 6'd0, 0, "j_jump", JMP);
    // illegal opcode: one-cycle pulse in DECODE, then straight back to FETCH
    cyc(0, 6'b111111, 6'd0, 0, "ill_fetch", F);
    cyc(0, 6'b111111, 6'd0, 0, "ill_decode", D(1));
    cyc(0, 6'b111111, 6'd0, 0, "ill_refetch", F);
    // sw abandoned by reset in MEMADR
    cyc(0, OP_SW, 6'd0, 0, "swr_decode", D(0));
    cyc(1, OP_SW, 6'd0, 0, "swr_memadr_rst", MA);
    cyc(0, OP_SW, 6'd0, 0, "swr_after_rst", F);
    // lw with reset during MEMWB: write enable must be masked
    cyc(0, OP_LW, 6'd0, 0, "lwr_decode", D(0));
    cyc(0, OP_LW, 6'd0, 0, "lwr_memadr", MA);
    cyc(0, OP_LW, 6'd0, 0, "lwr_memrd", MR);
    cyc(1, OP_LW, 6'd0, 0, "lwr_memwb_rst", MWB_RST);
    cyc(0, OP_LW, 6'd0, 0, "lwr_after_rst", F);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clock);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
